nes_controller_datapath: RTL and testbench
==========================================

# nes_controller_datapath

Datapath stage driven by the NES controller FSM: consumes the 10-bit control word `cw_NESController`, runs the poll-interval delay counter and the per-state pulse counter, drives the NES latch/clock pins, samples the serial data line and assembles an 8-bit button word. It returns the 2-bit status word `sw_NESController` that advances the FSM, and feeds the paddle logic with debounced, frame-aligned button states.

## Interface
- `DELAY_MAX`, 419583: clk cycles per poll interval (60 Hz at 25.175 MHz); must be ≥ 2.
- `PULSE_CYCLES`, 150: clk cycles per FSM state (6 µs half-period); must be ≥ 4.
- `clk`  in  1  system clock; all logic on the rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `cw_NESController`  in  10  control word: [9:8] delay ctrl, [7:4] data-read code, [3] latch enable, [2] clock enable, [1:0] pulse ctrl.
- `sw_NESController`  out  2  status: [1] delay terminal, [0] pulse terminal.
- `nes_data`  in  1  serial data from controller, asynchronous, active-low (0 = pressed).
- `nes_latch`  out  1  latch pin to controller.
- `nes_pulse`  out  1  clock pin to controller.
- `buttons`  out  8  {Right, Left, Down, Up, Start, Select, B, A}, active-high pressed.
- `buttons_valid`  out  1  one-cycle strobe when `buttons` is updated.

## Operation
- Counter ctrl encoding, both counters: 00 hold, 01 increment, 11 synchronous clear to 0, 10 treated as hold.
- Delay counter: width clog2(DELAY_MAX); increment at DELAY_MAX-1 wraps to 0. `sw[1]` = (count == DELAY_MAX-1), combinational from the register.
- Pulse counter: width clog2(PULSE_CYCLES); increment at PULSE_CYCLES-1 wraps to 0. `sw[0]` = (count == PULSE_CYCLES-1), combinational from the register.
- `nes_data` passes through a 2-flop synchronizer (both flops reset to 1); all sampling uses the synchronized value `d_s`.
- Data-read code 1..8 selects shadow bit code-1. On a cycle where code ∈ 1..8 and `sw[0]`=1, shadow[code-1] <= ~d_s. Codes 0 and 9..15 sample nothing.
- Code 8 sample additionally commits: `buttons` <= {~d_s, shadow[6:0]} on the same edge; `buttons_valid` = 1 for the following cycle only.
- Shadow is not cleared between frames; every frame overwrites all 8 bits.
- `nes_latch` <= cw[3], `nes_pulse` <= cw[2] (registered, glitch-free pins).

## Timing
- Reset values: both counters 0, shadow 0, `buttons` 0, `buttons_valid` 0, `nes_latch` 0, `nes_pulse` 0, synchronizer 1; hence `sw_NESController` = 00.
- Reset mid-frame discards the partial shadow, no `buttons_valid`; next complete frame commits normally.
- `sw` reacts to counter state with zero latency; counters update on the edge after cw is presented, so FSM and counter advance on the same edge at wrap.
- Latch/clock pins lag cw by 1 cycle; `nes_data` to `d_s` latency 2 cycles (covered by PULSE_CYCLES ≥ 4).
- `buttons_valid` asserts 1 cycle after the Right-sample edge; never two consecutive cycles.
- Per-button sample point: last cycle of its `*_low` state, PULSE_CYCLES-1 cycles after entry.

## Test plan
(Bench uses DELAY_MAX=20, PULSE_CYCLES=4.)
- Reset held 3 cycles with cw=10'h3FF, nes_data=0 -> sw=00, buttons=0, valid=0, latch=pulse=0 during and 1 cycle after.
- cw=10'b01_0000_0_0_11 from reset -> sw[1] rises after exactly 19 edges, falls the next cycle (wrap), sw[0] stays 0.
- cw[1:0]=01 continuous -> sw[0] high on every 4th cycle; cw[1:0]=10 freezes it; 11 returns count to 0.
- cw[3:2] toggled 00->10->01 -> nes_latch/nes_pulse follow exactly 1 cycle later.
- FSM model plus NES controller model, nes_data low only in the A and Right windows -> buttons=8'b1000_0001, single-cycle valid; next frame all high -> buttons=8'h00.
- Reset asserted after A sampled, released -> no valid for that frame; next frame with Start pressed -> buttons=8'b0000_1000.

Source files
------------

// File: rtl/nes_controller_datapath_if.sv
// Control/status and button-output bundle between the NES controller FSM,
// its datapath and the paddle logic.
interface nes_controller_datapath_if;
    logic [9:0] cw_NESController;
    logic [1:0] sw_NESController;
    logic [7:0] buttons;
    logic       buttons_valid;

    modport master (
        output cw_NESController,
        input  sw_NESController,
        input  buttons,
        input  buttons_valid
    );

    modport slave (
        input  cw_NESController,
        output sw_NESController,
        output buttons,
        output buttons_valid
    );
endinterface

// File: rtl/nes_controller_datapath.sv
// NES controller datapath: poll/pulse counters, latch/clock pins, serial data
// sampling into a shadow register and frame-aligned button commit.
module nes_controller_datapath #(
    parameter int unsigned DELAY_MAX    = 419583,
    parameter int unsigned PULSE_CYCLES = 150
) (
    input  logic                      clk,
    input  logic                      reset,
    nes_controller_datapath_if.slave  dp,
    input  logic                      nes_data,
    output logic                      nes_latch,
    output logic                      nes_pulse
);

    localparam int unsigned DW = $clog2(DELAY_MAX);
    localparam int unsigned PW = $clog2(PULSE_CYCLES);
    localparam logic [DW-1:0] DELAY_LAST = DW'(DELAY_MAX - 1);
    localparam logic [PW-1:0] PULSE_LAST = PW'(PULSE_CYCLES - 1);
    localparam logic [1:0] CTRL_INC = 2'b01;
    localparam logic [1:0] CTRL_CLR = 2'b11;
    localparam logic [3:0] CODE_RIGHT = 4'd8;

    logic [DW-1:0] delay_cnt_q, delay_cnt_d;
    logic [PW-1:0] pulse_cnt_q, pulse_cnt_d;
    logic [1:0]    sync_q, sync_d;
    logic [7:0]    shadow_q, shadow_d;
    logic [7:0]    buttons_q, buttons_d;
    logic          valid_q, valid_d;
    logic          latch_q, latch_d;
    logic          pulse_q, pulse_d;

    logic [1:0] dly_ctrl;
    logic [1:0] pls_ctrl;
    logic [3:0] code;
    logic [2:0] bit_idx;
    logic       delay_term;
    logic       pulse_term;
    logic       sample;
    logic       d_s;

    assign dly_ctrl   = dp.cw_NESController[9:8];
    assign code       = dp.cw_NESController[7:4];
    assign pls_ctrl   = dp.cw_NESController[1:0];
    assign delay_term = (delay_cnt_q == DELAY_LAST);
    assign pulse_term = (pulse_cnt_q == PULSE_LAST);
    assign d_s        = sync_q[1];

    // Status is combinational from the counters so the FSM sees wrap with zero latency.
    assign dp.sw_NESController = {delay_term, pulse_term};
    assign dp.buttons          = buttons_q;
    assign dp.buttons_valid    = valid_q;
    assign nes_latch           = latch_q;
    assign nes_pulse           = pulse_q;

    always_comb begin
        delay_cnt_d = delay_cnt_q;
        pulse_cnt_d = pulse_cnt_q;
        sync_d      = {sync_q[0], nes_data};
        shadow_d    = shadow_q;
        buttons_d   = buttons_q;
        valid_d     = 1'b0;
        latch_d     = dp.cw_NESController[3];
        pulse_d     = dp.cw_NESController[2];
        bit_idx     = 3'(code - 4'd1);
        sample      = (code != 4'd0) && (code <= CODE_RIGHT) && pulse_term;

        case (dly_ctrl)
            CTRL_INC: delay_cnt_d = delay_term ? '0 : delay_cnt_q + DW'(1);
            CTRL_CLR: delay_cnt_d = '0;
            default:  delay_cnt_d = delay_cnt_q;
        endcase

        case (pls_ctrl)
            CTRL_INC: pulse_cnt_d = pulse_term ? '0 : pulse_cnt_q + PW'(1);
            CTRL_CLR: pulse_cnt_d = '0;
            default:  pulse_cnt_d = pulse_cnt_q;
        endcase

        // Right is the last bit of a frame: commit the whole word alongside it.
        if (sample) begin
            shadow_d[bit_idx] = ~d_s;
            if (code == CODE_RIGHT) begin
                buttons_d = {~d_s, shadow_q[6:0]};
                valid_d   = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            delay_cnt_q <= '0;
            pulse_cnt_q <= '0;
            sync_q      <= 2'b11;
            shadow_q    <= '0;
            buttons_q   <= '0;
            valid_q     <= 1'b0;
            latch_q     <= 1'b0;
            pulse_q     <= 1'b0;
        end else begin
            delay_cnt_q <= delay_cnt_d;
            pulse_cnt_q <= pulse_cnt_d;
            sync_q      <= sync_d;
            shadow_q    <= shadow_d;
            buttons_q   <= buttons_d;
            valid_q     <= valid_d;
            latch_q     <= latch_d;
            pulse_q     <= pulse_d;
        end
    end

endmodule

// File: tb/tb_nes_controller_datapath.sv
// Bench for nes_controller_datapath: directed vectors, a cycle model built from
// the counter/sampling rules, and literal checks pinning key moments.
module tb_nes_controller_datapath;

    localparam int DM = 20;
    localparam int PC = 4;

    logic clk;
    logic reset;
    logic nes_data;
    logic nes_latch;
    logic nes_pulse;

    nes_controller_datapath_if ifc();

    nes_controller_datapath #(.DELAY_MAX(DM), .PULSE_CYCLES(PC)) dut (
        .clk      (clk),
        .reset    (reset),
        .dp       (ifc),
        .nes_data (nes_data),
        .nes_latch(nes_latch),
        .nes_pulse(nes_pulse)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;
    int valid_cnt = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: counters as modular integers, synchronizer as a 2-deep delay line.
    int   m_dcnt = 0;
    int   m_pcnt = 0;
    bit   m_line[2] = '{1'b1, 1'b1};
    bit   m_shadow[8] = '{default: 1'b0};
    logic [7:0] m_buttons = 8'h00;
    bit   m_valid = 1'b0;
    bit   m_latch = 1'b0;
    bit   m_pulse = 1'b0;
    int   m_code;
    bit   m_ds;
    bit   m_pterm;

    always @(posedge clk) begin
        if (reset) begin
            m_dcnt = 0; m_pcnt = 0;
            m_line[0] = 1'b1; m_line[1] = 1'b1;
            for (int i = 0; i < 8; i++) m_shadow[i] = 1'b0;
            m_buttons = 8'h00; m_valid = 1'b0; m_latch = 1'b0; m_pulse = 1'b0;
        end else begin
            m_code  = int'(ifc.cw_NESController[7:4]);
            m_ds    = m_line[1];
            m_pterm = (m_pcnt == PC - 1);
            m_valid = 1'b0;
            if (m_code >= 1 && m_code <= 8 && m_pterm) begin
                m_shadow[m_code - 1] = !m_ds;
                if (m_code == 8) begin
                    for (int i = 0; i < 8; i++) m_buttons[i] = m_shadow[i];
                    m_valid = 1'b1;
                end
            end
            case (ifc.cw_NESController[9:8])
                2'b01:   m_dcnt = (m_dcnt + 1) % DM;
                2'b11:   m_dcnt = 0;
                default: ;
            endcase
            case (ifc.cw_NESController[1:0])
                2'b01:   m_pcnt = (m_pcnt + 1) % PC;
                2'b11:   m_pcnt = 0;
                default: ;
            endcase
            m_line[1] = m_line[0];
            m_line[0] = nes_data;
            m_latch = ifc.cw_NESController[3];
            m_pulse = ifc.cw_NESController[2];
        end
    end

    // Every-cycle comparison against the model, away from the active edge.
    always @(negedge clk) begin
        check("sw", 32'(ifc.sw_NESController), 32'({m_dcnt == DM - 1, m_pcnt == PC - 1}));
        check("latch", 32'(nes_latch), 32'(m_latch));
        check("pulse", 32'(nes_pulse), 32'(m_pulse));
        check("buttons", 32'(ifc.buttons), 32'(m_buttons));
        check("valid", 32'(ifc.buttons_valid), 32'(m_valid));
        if (ifc.buttons_valid === 1'b1) valid_cnt++;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One FSM state is PC cycles with the pulse counter free-running.
    task automatic run_state(input logic [9:0] cw);
        ifc.cw_NESController = cw;
        repeat (PC) tick();
    endtask

    // Frame: latch, then low/high pairs per button; data changes at each high state.
    task automatic run_frame(input logic [7:0] pressed, input int n_states);
        ifc.cw_NESController = 10'b00_0000_0_0_11;
        tick();
        for (int s = 0; s < n_states; s++) begin
            if (s == 0) begin
                nes_data = ~pressed[0];
                run_state(10'b00_0000_1_0_01);
            end else if (s % 2 == 1) begin
                run_state({2'b00, 4'((s + 1) / 2), 1'b0, 1'b0, 2'b01});
            end else begin
                nes_data = (s / 2 < 8) ? ~pressed[3'(s / 2)] : 1'b1;
                run_state(10'b00_0000_0_1_01);
            end
        end
        ifc.cw_NESController = 10'b00_0000_0_0_00;
        tick();
        tick();
    endtask

    int v0;

    initial begin
        reset = 1'b1;
        ifc.cw_NESController = 10'h3FF;
        nes_data = 1'b0;

        repeat (3) tick();
        check("rst_sw", 32'(ifc.sw_NESController), 32'd0);
        check("rst_buttons", 32'(ifc.buttons), 32'd0);
        check("rst_valid", 32'(ifc.buttons_valid), 32'd0);
        check("rst_pins", 32'({nes_latch, nes_pulse}), 32'd0);

        // Delay counter: terminal after exactly 19 increments, wraps on the 20th.
        reset = 1'b0;
        ifc.cw_NESController = 10'b01_0000_0_0_11;
        check("post_rst_sw", 32'(ifc.sw_NESController), 32'd0);
        tick();
        check("post_rst_pins", 32'({nes_latch, nes_pulse}), 32'd0);
        repeat (17) tick();
        check("delay_18", 32'(ifc.sw_NESController), 32'b00);
        tick();
        check("delay_19", 32'(ifc.sw_NESController), 32'b10);
        tick();
        check("delay_wrap", 32'(ifc.sw_NESController), 32'b00);

        // Pulse counter: every 4th cycle, freeze on 10, clear on 11.
        ifc.cw_NESController = 10'b00_0000_0_0_01;
        repeat (3) tick();
        check("pulse_3", 32'(ifc.sw_NESController), 32'b01);
        tick();
        check("pulse_wrap", 32'(ifc.sw_NESController), 32'b00);
        repeat (3) tick();
        check("pulse_7", 32'(ifc.sw_NESController), 32'b01);
        ifc.cw_NESController = 10'b00_0000_0_0_10;
        repeat (2) tick();
        check("pulse_freeze", 32'(ifc.sw_NESController), 32'b01);
        ifc.cw_NESController = 10'b00_0000_0_0_11;
        tick();
        check("pulse_clear", 32'(ifc.sw_NESController), 32'b00);

        // Pins lag cw by one cycle.
        ifc.cw_NESController = 10'b00_0000_1_0_00;
        check("latch_lag", 32'({nes_latch, nes_pulse}), 32'b00);
        tick();
        check("latch_hi", 32'({nes_latch, nes_pulse}), 32'b10);
        ifc.cw_NESController = 10'b00_0000_0_1_00;
        tick();
        check("pulse_hi", 32'({nes_latch, nes_pulse}), 32'b01);
        ifc.cw_NESController = 10'b00_0000_0_0_00;
        tick();
        check("pins_lo", 32'({nes_latch, nes_pulse}), 32'b00);

        // Frame with A and Right pressed, then a frame with nothing pressed.
        v0 = valid_cnt;
        run_frame(8'b1000_0001, 17);
        check("frame1_buttons", 32'(ifc.buttons), 32'h81);
        check("frame1_valids", 32'(valid_cnt - v0), 32'd1);
        v0 = valid_cnt;
        run_frame(8'h00, 17);
        check("frame2_buttons", 32'(ifc.buttons), 32'h00);
        check("frame2_valids", 32'(valid_cnt - v0), 32'd1);

        // Reset after A is sampled discards the frame; the next frame commits Start.
        run_frame(8'h81, 17);
        v0 = valid_cnt;
        run_frame(8'hFF, 3);
        reset = 1'b1;
        repeat (2) tick();
        reset = 1'b0;
        tick();
        check("abort_valids", 32'(valid_cnt - v0), 32'd0);
        check("abort_buttons", 32'(ifc.buttons), 32'h00);
        v0 = valid_cnt;
        run_frame(8'b0000_1000, 17);
        check("frame3_buttons", 32'(ifc.buttons), 32'h08);
        check("frame3_valids", 32'(valid_cnt - v0), 32'd1);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
